hls_perf_monitor: RTL and testbench

- Synthesizable, parametrised per-channel performance monitor for HLS block-level handshakes (ap_start/ap_done) and loop-iteration pulses.
- Sits beside the accelerator top, such as FC_CIF_0_1, with one channel per sub-function or pipelined loop.
- Per channel it counts invocations, per-invocation latency, busy cycles and loop iterations.
- Software and the bench read results through a registered request/response port.

---
 rtl/hls_perf_monitor_pkg.sv | 28 ++
 rtl/hls_perf_monitor_if.sv | 31 +++
 rtl/hls_perf_ch.sv | 150 +++++++++++++++
 rtl/hls_perf_monitor.sv | 97 +++++++++
 tb/tb_hls_perf_monitor.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/hls_perf_monitor_pkg.sv
// Shared types, read-select codes and saturating-increment helper for hls_perf_monitor.
package hls_perf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  localparam int unsigned CNT_W_MAX = 64;

  localparam logic [2:0] SEL_INV     = 3'd0;
  localparam logic [2:0] SEL_LAST    = 3'd1;
  localparam logic [2:0] SEL_MAX     = 3'd2;
  localparam logic [2:0] SEL_BUSY    = 3'd3;
  localparam logic [2:0] SEL_ITER    = 3'd4;
  localparam logic [2:0] SEL_MIN     = 3'd5;
  localparam logic [2:0] SEL_ORPH    = 3'd6;
  localparam logic [2:0] SEL_INVALID = 3'd7;

  // Increment v, sticking at the all-ones value of a w-bit counter.
  function automatic logic [CNT_W_MAX-1:0] cnt_sat(input logic [CNT_W_MAX-1:0] v,
                                                   input int unsigned w);
    logic [CNT_W_MAX-1:0] max_v;
    max_v = (w >= CNT_W_MAX) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/hls_perf_monitor_if.sv
// Handshake-monitor and read-port bundle for hls_perf_monitor (slave = monitor side).
interface hls_perf_monitor_if #(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0] ch_start_i;
  logic [NUM_CH-1:0] ch_done_i;
  logic [NUM_CH-1:0] ch_iter_i;
  logic              clear_i;
  logic              finish_i;
  logic              rd_req_i;
  logic [CH_W-1:0]   rd_ch_i;
  logic [2:0]        rd_sel_i;
  logic              rd_valid_o;
  logic [CNT_W-1:0]  rd_data_o;
  logic              rd_err_o;
  logic [NUM_CH-1:0] ovf_o;

  modport master (
    output ch_start_i, ch_done_i, ch_iter_i, clear_i, finish_i,
    output rd_req_i, rd_ch_i, rd_sel_i,
    input  rd_valid_o, rd_data_o, rd_err_o, ovf_o
  );

  modport slave (
    input  ch_start_i, ch_done_i, ch_iter_i, clear_i, finish_i,
    input  rd_req_i, rd_ch_i, rd_sel_i,
    output rd_valid_o, rd_data_o, rd_err_o, ovf_o
  );
endinterface

// File: rtl/hls_perf_ch.sv
// One monitored channel: ap_start/ap_done FSM plus saturating statistics counters.
// Optional min-latency tracking under HLS_PERF_MINLAT_EN.
module hls_perf_ch
  import hls_perf_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             finish_i,
  input  logic             start_i,
  input  logic             done_i,
  input  logic             iter_i,
  output logic [CNT_W-1:0] inv_o,
  output logic [CNT_W-1:0] last_o,
  output logic [CNT_W-1:0] max_o,
  output logic [CNT_W-1:0] busy_o,
  output logic [CNT_W-1:0] iter_o,
  output logic [CNT_W-1:0] orph_o,
`ifdef HLS_PERF_MINLAT_EN
  output logic [CNT_W-1:0] min_o,
`endif
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] ALL1 = '1;

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] lat_q, lat_d, last_q, last_d, max_q, max_d;
  logic [CNT_W-1:0] inv_q, inv_d, busy_q, busy_d, iter_q, iter_d, orph_q, orph_d;
  logic [CNT_W-1:0] lat_cur;
  logic             ovf_q, ovf_d, done_acc;
`ifdef HLS_PERF_MINLAT_EN
  logic [CNT_W-1:0] min_q, min_d;
`endif

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(cnt_sat(CNT_W_MAX'(v), CNT_W));
  endfunction

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    last_d   = last_q;
    max_d    = max_q;
    inv_d    = inv_q;
    busy_d   = busy_q;
    iter_d   = iter_q;
    orph_d   = orph_q;
    ovf_d    = ovf_q;
    lat_cur  = inc(lat_q);
    done_acc = 1'b0;
`ifdef HLS_PERF_MINLAT_EN
    min_d    = min_q;
`endif
    if (!finish_i) begin
      if (iter_i) iter_d = inc(iter_q);
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_d  = inc(busy_q);
            lat_cur = CNT_W'(1);
            lat_d   = lat_cur;
            if (done_i) done_acc = 1'b1;
            else        state_d  = RUN;
          end else if (done_i) begin
            orph_d = inc(orph_q);
          end
        end
        RUN: begin
          busy_d = inc(busy_q);
          lat_d  = lat_cur;
          if (done_i) begin
            done_acc = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      // Latency includes the done cycle itself.
      if (done_acc) begin
        last_d = lat_cur;
        inv_d  = inc(inv_q);
        if (lat_cur > max_q) max_d = lat_cur;
`ifdef HLS_PERF_MINLAT_EN
        if (lat_cur < min_q) min_d = lat_cur;
`endif
      end
      ovf_d = ovf_q | (lat_d == ALL1) | (last_d == ALL1) | (max_d == ALL1) |
              (inv_d == ALL1) | (busy_d == ALL1) | (iter_d == ALL1) | (orph_d == ALL1);
    end
  end

  // Synchronous clear has the same effect as reset and beats finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      last_q  <= '0;
      max_q   <= '0;
      inv_q   <= '0;
      busy_q  <= '0;
      iter_q  <= '0;
      orph_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef HLS_PERF_MINLAT_EN
      min_q   <= '1;
`endif
    end else if (clear_i) begin
      state_q <= IDLE;
      lat_q   <= '0;
      last_q  <= '0;
      max_q   <= '0;
      inv_q   <= '0;
      busy_q  <= '0;
      iter_q  <= '0;
      orph_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef HLS_PERF_MINLAT_EN
      min_q   <= '1;
`endif
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      last_q  <= last_d;
      max_q   <= max_d;
      inv_q   <= inv_d;
      busy_q  <= busy_d;
      iter_q  <= iter_d;
      orph_q  <= orph_d;
      ovf_q   <= ovf_d;
`ifdef HLS_PERF_MINLAT_EN
      min_q   <= min_d;
`endif
    end
  end

  assign inv_o  = inv_q;
  assign last_o = last_q;
  assign max_o  = max_q;
  assign busy_o = busy_q;
  assign iter_o = iter_q;
  assign orph_o = orph_q;
  assign ovf_o  = ovf_q;
`ifdef HLS_PERF_MINLAT_EN
  assign min_o  = min_q;
`endif

endmodule

// File: rtl/hls_perf_monitor.sv
// Per-channel HLS performance monitor: channel array plus registered read port.
// Define HLS_PERF_MINLAT_EN to add per-channel minimum-latency tracking (rd_sel 5).
module hls_perf_monitor
  import hls_perf_pkg::*;
#(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  hls_perf_monitor_if.slave bus
);

  logic [CNT_W-1:0]  inv_w  [NUM_CH];
  logic [CNT_W-1:0]  last_w [NUM_CH];
  logic [CNT_W-1:0]  max_w  [NUM_CH];
  logic [CNT_W-1:0]  busy_w [NUM_CH];
  logic [CNT_W-1:0]  iter_w [NUM_CH];
  logic [CNT_W-1:0]  orph_w [NUM_CH];
`ifdef HLS_PERF_MINLAT_EN
  logic [CNT_W-1:0]  min_w  [NUM_CH];
`endif
  logic [NUM_CH-1:0] ovf_w;

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    hls_perf_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (bus.clear_i),
      .finish_i (bus.finish_i),
      .start_i  (bus.ch_start_i[g]),
      .done_i   (bus.ch_done_i[g]),
      .iter_i   (bus.ch_iter_i[g]),
      .inv_o    (inv_w[g]),
      .last_o   (last_w[g]),
      .max_o    (max_w[g]),
      .busy_o   (busy_w[g]),
      .iter_o   (iter_w[g]),
      .orph_o   (orph_w[g]),
`ifdef HLS_PERF_MINLAT_EN
      .min_o    (min_w[g]),
`endif
      .ovf_o    (ovf_w[g])
    );
  end

  logic             rd_valid_q, rd_valid_d, rd_err_q, rd_err_d, rd_bad;
  logic [CNT_W-1:0] rd_data_q, rd_data_d, rd_val;

  // Read mux; a bad channel or unused select yields zero data with an error.
  always_comb begin
    rd_val = '0;
    rd_bad = (32'(bus.rd_ch_i) >= NUM_CH) || (bus.rd_sel_i == SEL_INVALID);
`ifndef HLS_PERF_MINLAT_EN
    rd_bad = rd_bad || (bus.rd_sel_i == SEL_MIN);
`endif
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.rd_ch_i == CH_W'(i)) begin
        case (bus.rd_sel_i)
          SEL_INV:  rd_val = inv_w[i];
          SEL_LAST: rd_val = last_w[i];
          SEL_MAX:  rd_val = max_w[i];
          SEL_BUSY: rd_val = busy_w[i];
          SEL_ITER: rd_val = iter_w[i];
`ifdef HLS_PERF_MINLAT_EN
          SEL_MIN:  rd_val = min_w[i];
`endif
          SEL_ORPH: rd_val = orph_w[i];
          default:  rd_val = '0;
        endcase
      end
    end
    rd_valid_d = bus.rd_req_i;
    rd_err_d   = bus.rd_req_i & rd_bad;
    rd_data_d  = rd_data_q;
    if (bus.rd_req_i) rd_data_d = rd_bad ? '0 : rd_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_err_o   = rd_err_q;
  assign bus.rd_data_o  = rd_data_q;
  assign bus.ovf_o      = ovf_w;

endmodule

// File: tb/tb_hls_perf_monitor.sv
// Directed self-checking bench for hls_perf_monitor (NUM_CH=5, CNT_W=8).
module tb_hls_perf_monitor;
  import hls_perf_pkg::*;

  localparam int unsigned NUM_CH = 5;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CH_W   = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hls_perf_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

  hls_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle read request, then check the response registered at the next edge.
  task automatic do_read(input string tag, input int unsigned ch, input logic [2:0] sel,
                         input int unsigned exp_data, input int unsigned exp_err);
    bus.rd_req_i = 1'b1;
    bus.rd_ch_i  = 3'(ch);
    bus.rd_sel_i = sel;
    tick(1);
    bus.rd_req_i = 1'b0;
    check({tag, "_valid"}, 64'(bus.rd_valid_o), 64'd1);
    check({tag, "_data"},  64'(bus.rd_data_o),  64'(exp_data));
    check({tag, "_err"},   64'(bus.rd_err_o),   64'(exp_err));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.ch_start_i = '0;
    bus.ch_done_i  = '0;
    bus.ch_iter_i  = '0;
    bus.clear_i    = 1'b0;
    bus.finish_i   = 1'b0;
    bus.rd_req_i   = 1'b0;
    bus.rd_ch_i    = '0;
    bus.rd_sel_i   = '0;
    #23 rst_n = 1'b1;
    tick(2);

    // Reset state
    check("rst_valid", 64'(bus.rd_valid_o), 64'd0);
    check("rst_data",  64'(bus.rd_data_o),  64'd0);
    check("rst_err",   64'(bus.rd_err_o),   64'd0);
    check("rst_ovf",   64'(bus.ovf_o),      64'd0);
    do_read("rst_inv0", 0, SEL_INV, 0, 0);

    // Ch0: start held 3 cycles (extra ignored in RUN), done on 10th cycle
    bus.ch_start_i = 5'b00001;
    tick(3);
    bus.ch_start_i = '0;
    tick(6);
    bus.ch_done_i = 5'b00001;
    tick(1);
    bus.ch_done_i = '0;
    do_read("c0_inv",  0, SEL_INV,  1,  0);
    do_read("c0_last", 0, SEL_LAST, 10, 0);
    do_read("c0_max",  0, SEL_MAX,  10, 0);
    do_read("c0_busy", 0, SEL_BUSY, 10, 0);
    tick(1);
    check("hold_valid", 64'(bus.rd_valid_o), 64'd0);
    check("hold_data",  64'(bus.rd_data_o),  64'd10);

    // Ch2: start+done same cycle, then back-to-back 4-cycle run
    bus.ch_start_i = 5'b00100;
    bus.ch_done_i  = 5'b00100;
    tick(1);
    bus.ch_done_i  = '0;
    tick(1);
    bus.ch_start_i = '0;
    tick(2);
    bus.ch_done_i = 5'b00100;
    tick(1);
    bus.ch_done_i = '0;
    do_read("c2_inv",  2, SEL_INV,  2, 0);
    do_read("c2_last", 2, SEL_LAST, 4, 0);
    do_read("c2_max",  2, SEL_MAX,  4, 0);
    do_read("c2_busy", 2, SEL_BUSY, 5, 0);
`ifdef HLS_PERF_MINLAT_EN
    do_read("c2_min",  2, SEL_MIN,  1, 0);
`else
    do_read("c2_min",  2, SEL_MIN,  0, 1);
`endif

    // Ch3 orphan done, then bad reads
    bus.ch_done_i = 5'b01000;
    tick(1);
    bus.ch_done_i = '0;
    do_read("c3_orph", 3, SEL_ORPH, 1, 0);
    do_read("c3_inv",  3, SEL_INV,  0, 0);
    do_read("c3_busy", 3, SEL_BUSY, 0, 0);
    do_read("c1_last", 1, SEL_LAST, 0, 0);
    do_read("badch",   5, SEL_INV,  0, 1);
    do_read("c0_inv2", 0, SEL_INV,  1, 0);
    do_read("badsel",  0, SEL_INVALID, 0, 1);

    // Ch4: freeze 20 cycles mid-run, iter pulses during freeze ignored
    bus.ch_start_i = 5'b10000;
    tick(1);
    bus.ch_start_i = '0;
    tick(2);
    bus.finish_i  = 1'b1;
    bus.ch_iter_i = 5'b10000;
    tick(18);
    do_read("frz_busy", 4, SEL_BUSY, 3, 0);
    do_read("frz_iter", 4, SEL_ITER, 0, 0);
    bus.finish_i  = 1'b0;
    bus.ch_iter_i = '0;
    tick(1);
    bus.ch_done_i = 5'b10000;
    tick(1);
    bus.ch_done_i = '0;
    do_read("c4_last", 4, SEL_LAST, 5, 0);
    do_read("c4_busy", 4, SEL_BUSY, 5, 0);
    do_read("c4_inv",  4, SEL_INV,  1, 0);

    // Ch1: 300 iteration pulses saturate at 255 and set ovf[1]
    bus.ch_iter_i = 5'b00010;
    tick(300);
    bus.ch_iter_i = '0;
    check("sat_ovf", 64'(bus.ovf_o), 64'b00010);
    do_read("sat_iter", 1, SEL_ITER, 255, 0);
    bus.clear_i = 1'b1;
    tick(1);
    bus.clear_i = 1'b0;
    check("clr_ovf", 64'(bus.ovf_o), 64'd0);
    do_read("clr_iter", 1, SEL_ITER, 0, 0);
    do_read("clr_c2inv", 2, SEL_INV, 0, 0);

    // Async reset mid-RUN with ovf set and a live read response
    bus.ch_start_i = 5'b00001;
    bus.ch_iter_i  = 5'b00010;
    tick(1);
    bus.ch_start_i = '0;
    tick(259);
    bus.ch_iter_i = '0;
    check("pre_rst_ovf", 64'(bus.ovf_o), 64'b00011);
    do_read("pre_rst_iter", 1, SEL_ITER, 255, 0);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.rd_valid_o), 64'd0);
    check("arst_data",  64'(bus.rd_data_o),  64'd0);
    check("arst_ovf",   64'(bus.ovf_o),      64'd0);
    #2 rst_n = 1'b1;
    tick(1);
    bus.ch_start_i = 5'b00001;
    tick(1);
    bus.ch_start_i = '0;
    bus.ch_done_i  = 5'b00001;
    tick(1);
    bus.ch_done_i = '0;
    do_read("post_last", 0, SEL_LAST, 2, 0);
    do_read("post_inv",  0, SEL_INV,  1, 0);
    do_read("post_busy", 0, SEL_BUSY, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
